// File: rtl/shared_pkg.sv
// Shared types for the SPI RAM access arbiter: arbiter states,
// SPI command encoding and the default RAM data width.
package shared_pkg;

   localparam int MEM_WIDTH = 8;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_LOCKED   = 2'd1,
      ARB_WAIT_RSP = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } spi_cmd_e;

   function automatic logic is_addr(spi_cmd_e c);
      return (c == WR_ADDR) || (c == RD_ADDR);
   endfunction

endpackage

// File: rtl/ram_arb_req_slot.sv
// One-deep command capture slot with valid flag and overflow detect.
// Ports: clk, rst_n, cap (capture strobe), din (word), grant (slot
// consumed this edge), valid/word (slot contents), ovf (capture refused).
module ram_arb_req_slot
#(
   parameter int WORD_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cap,
   input  logic [WORD_W-1:0] din,
   input  logic              grant,
   output logic              valid,
   output logic [WORD_W-1:0] word,
   output logic              ovf
);
   import shared_pkg::*;

   // A slot being granted on the same edge counts as free, so the
   // incoming word replaces the one leaving and nothing is lost.
   assign ovf = cap && valid && !grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         word  <= '0;
      end else if (cap && !ovf) begin
         valid <= 1'b1;
         word  <= din;
      end else if (grant) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares a single-port SPI RAM between the SPI slave (port 0, pulse only)
// and a local host (port 1, valid/ready). Address+data pairs stay atomic
// per requester; read data is routed back to the requester that issued it.
// Ports: s0_* SPI slave side, s1_* host side, ram_* RAM side, err_* sticky
// error flags. Optional: RAM_ARB_TIMEOUT_EN enables the LOCK_TIMEOUT
// forced release; otherwise err_timeout is tied low.
module ram_access_arbiter
#(
   parameter int MEM_WIDTH    = shared_pkg::MEM_WIDTH,
   parameter int LOCK_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [MEM_WIDTH+1:0] s0_rx_data,
   input  logic                 s0_rx_valid,
   output logic                 s0_tx_valid,
   output logic [MEM_WIDTH-1:0] s0_dout,
   input  logic [MEM_WIDTH+1:0] s1_req_data,
   input  logic                 s1_req_valid,
   output logic                 s1_req_ready,
   output logic                 s1_rsp_valid,
   output logic [MEM_WIDTH-1:0] s1_rsp_data,
   output logic [MEM_WIDTH+1:0] ram_rx_data,
   output logic                 ram_rx_valid,
   input  logic                 ram_tx_valid,
   input  logic [MEM_WIDTH-1:0] ram_dout,
   output logic                 err_s0_ovf,
   output logic                 err_unexp_rsp,
   output logic                 err_timeout
);
   import shared_pkg::*;

   localparam int WORD_W = MEM_WIDTH + 2;

   arb_state_e          state;
   logic                owner;
   logic                rr;
   logic                v0, v1;
   logic [WORD_W-1:0]   w0, w1;
   logic                ovf0;
   logic                unused_ovf1;
   logic                gnt0, gnt1, gnt_any;
   logic [WORD_W-1:0]   gnt_word;
   spi_cmd_e            gnt_cmd;
   logic                s1_cap;

   assign s1_req_ready = !v1;
   assign s1_cap       = s1_req_valid && s1_req_ready;

   ram_arb_req_slot #(.WORD_W(WORD_W)) u_slot0 (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (s0_rx_valid),
      .din   (s0_rx_data),
      .grant (gnt0),
      .valid (v0),
      .word  (w0),
      .ovf   (ovf0)
   );

   // Port 1 only captures when ready, so it can never overflow.
   ram_arb_req_slot #(.WORD_W(WORD_W)) u_slot1 (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (s1_cap),
      .din   (s1_req_data),
      .grant (gnt1),
      .valid (v1),
      .word  (w1),
      .ovf   (unused_ovf1)
   );

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (v0 && v1) begin
               gnt0 = !rr;
               gnt1 = rr;
            end else begin
               gnt0 = v0;
               gnt1 = v1;
            end
         end
         ARB_LOCKED: begin
            gnt0 = v0 && !owner;
            gnt1 = v1 && owner;
         end
         default: ;
      endcase
   end

   assign gnt_any  = gnt0 || gnt1;
   assign gnt_word = gnt1 ? w1 : w0;
   assign gnt_cmd  = spi_cmd_e'(gnt_word[MEM_WIDTH+1:MEM_WIDTH]);

`ifdef RAM_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;
   assign tmo_hit = (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
`else
   localparam int unused_lock_timeout = LOCK_TIMEOUT;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ARB_IDLE;
         owner         <= 1'b0;
         rr            <= 1'b0;
         ram_rx_valid  <= 1'b0;
         ram_rx_data   <= '0;
         s0_tx_valid   <= 1'b0;
         s0_dout       <= '0;
         s1_rsp_valid  <= 1'b0;
         s1_rsp_data   <= '0;
         err_s0_ovf    <= 1'b0;
         err_unexp_rsp <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
         tmo_cnt       <= '0;
         err_timeout   <= 1'b0;
`endif
      end else begin
         ram_rx_valid <= gnt_any;
         if (gnt_any)
            ram_rx_data <= gnt_word;
         s0_tx_valid  <= 1'b0;
         s1_rsp_valid <= 1'b0;
         if (ovf0)
            err_s0_ovf <= 1'b1;
         if (ram_tx_valid && (state != ARB_WAIT_RSP))
            err_unexp_rsp <= 1'b1;
`ifdef RAM_ARB_TIMEOUT_EN
         tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
         unique case (state)
            ARB_IDLE: begin
               if (gnt_any) begin
                  rr    <= !gnt1;
                  owner <= gnt1;
`ifdef RAM_ARB_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
                  if (is_addr(gnt_cmd))
                     state <= ARB_LOCKED;
                  else if (gnt_cmd == RD_DATA)
                     state <= ARB_WAIT_RSP;
               end
            end
            ARB_LOCKED: begin
               // A real grant is progress and wins over a same-edge timeout.
               if (gnt_any) begin
                  if (gnt_cmd == WR_DATA) begin
                     state <= ARB_IDLE;
                  end else if (gnt_cmd == RD_DATA) begin
                     state <= ARB_WAIT_RSP;
`ifdef RAM_ARB_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                  end
               end
`ifdef RAM_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  state       <= ARB_IDLE;
                  rr          <= !owner;
                  err_timeout <= 1'b1;
               end
`endif
            end
            ARB_WAIT_RSP: begin
               if (ram_tx_valid) begin
                  if (owner) begin
                     s1_rsp_valid <= 1'b1;
                     s1_rsp_data  <= ram_dout;
                  end else begin
                     s0_tx_valid <= 1'b1;
                     s0_dout     <= ram_dout;
                  end
                  state <= ARB_IDLE;
               end
`ifdef RAM_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  state       <= ARB_IDLE;
                  rr          <= !owner;
                  err_timeout <= 1'b1;
               end
`endif
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
